alu_cmd_parser: RTL

- Byte-stream command processor between the UART receiver output (m_axis side) and the UART transmitter input (s_axis side) inside top.
- Parses framed packets: opcode, reserved byte, 16-bit little-endian total length, then payload.
- Executes echo, 32-bit add or 32-bit multiply, and emits response bytes on a valid/ready stream.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_mul32_seq.sv | 40 ++++
 rtl/alu_cmd_parser.sv | 124 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, header size and parser state encoding shared by the ALU command parser.
package alu_pkg;
  localparam logic [7:0] OPC_ECHO = 8'hEC;
  localparam logic [7:0] OPC_ADD = 8'hA0;
  localparam logic [7:0] OPC_MUL = 8'hA1;
  localparam int HEADER_BYTES = 4;
  typedef enum logic [3:0] {
    S_OPC,
    S_RSVD,
    S_LEN_LO,
    S_LEN_HI,
    S_ECHO,
    S_OPND,
    S_MUL_BUSY,
    S_RESULT,
    S_DRAIN
  } state_t;
endpackage

// File: rtl/alu_mul32_seq.sv
// alu_mul32_seq: 32-cycle shift-add multiplier returning the low 32 product bits; only built with ALU_MUL_EN.
`ifdef ALU_MUL_EN
module alu_mul32_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] p
);
  logic [31:0] a_q, b_q, p_q;
  logic [4:0] cnt_q;
  logic busy_q;
  // p is the partial product including the current step, so it is final when done is high
  assign p = p_q + (b_q[0] ? a_q : 32'd0);
  assign done = busy_q & (cnt_q == 5'd31);
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      a_q <= a;
      b_q <= b;
      p_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      p_q <= p;
      a_q <= a_q << 1;
      b_q <= b_q >> 1;
      cnt_q <= cnt_q + 5'd1;
      busy_q <= !done;
    end
  end
endmodule
`endif

// File: rtl/alu_cmd_parser.sv
// alu_cmd_parser: framed byte-stream echo/add32/mul32 command processor.
// Multiply opcode and its sequential multiplier exist only when ALU_MUL_EN is defined.
module alu_cmd_parser
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH_P = 8,
  parameter int OPERAND_BYTES_P = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH_P-1:0] s_data_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [DATA_WIDTH_P-1:0] m_data_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic                    err_o
);
  localparam int W = DATA_WIDTH_P * OPERAND_BYTES_P;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  state_t state_q, state_d;
  logic [DATA_WIDTH_P-1:0] opc_q, len_lo_q, out_q, res_byte;
  logic [15:0] rem_q, len, rem_n;
  logic [W-1:0] shift_q, acc_q, op, mul_p;
  logic [1:0] byte_cnt_q, res_cnt_q;
  logic first_q, out_v_q, err_q, hdr_err, s_acc, short, is_arith, last, opnd_done, mul_start, mul_done;
  assign s_acc = s_valid_i & s_ready_o;
  assign len = {s_data_i, len_lo_q};
  assign short = len < 16'(HEADER_BYTES);
  assign rem_n = len - 16'(HEADER_BYTES);
  assign is_arith = (opc_q == OPC_ADD) | (MUL_EN & (opc_q == OPC_MUL));
  assign last = rem_q == 16'd1;
  assign op = {s_data_i, shift_q[W-1:DATA_WIDTH_P]};
  assign opnd_done = s_acc & (state_q == S_OPND) & (byte_cnt_q == 2'd3);
  assign mul_start = opnd_done & !first_q & MUL_EN & (opc_q == OPC_MUL);
  assign res_byte = DATA_WIDTH_P'(acc_q >> {res_cnt_q, 3'd0});
  assign err_o = err_q;
`ifdef ALU_MUL_EN
  alu_mul32_seq u_mul (
    .clk(clk),
    .rst(rst),
    .start(mul_start),
    .a(acc_q),
    .b(op),
    .done(mul_done),
    .p(mul_p)
  );
`else
  assign mul_done = 1'b0;
  assign mul_p = '0;
`endif
  always_ff @(posedge clk) begin
    state_q <= rst ? S_OPC : state_d;
  end
  always_comb begin
    state_d = state_q;
    hdr_err = 1'b0;
    case (state_q)
      S_OPC: state_d = s_acc ? S_RSVD : S_OPC;
      S_RSVD: state_d = s_acc ? S_LEN_LO : S_RSVD;
      S_LEN_LO: state_d = s_acc ? S_LEN_HI : S_LEN_LO;
      S_LEN_HI: if (s_acc) begin
        hdr_err = short | ((opc_q != OPC_ECHO) & (!is_arith | (rem_n < 16'd8) | (rem_n[1:0] != 2'd0)));
        state_d = (short | (rem_n == 16'd0)) ? S_OPC : hdr_err ? S_DRAIN : (opc_q == OPC_ECHO) ? S_ECHO : S_OPND;
      end
      S_ECHO, S_DRAIN: state_d = (s_acc & last) ? S_OPC : state_q;
      S_OPND: state_d = !opnd_done ? S_OPND : mul_start ? S_MUL_BUSY : last ? S_RESULT : S_OPND;
      S_MUL_BUSY: state_d = !mul_done ? S_MUL_BUSY : (rem_q == 16'd0) ? S_RESULT : S_OPND;
      S_RESULT: state_d = (m_ready_i & (res_cnt_q == 2'd3)) ? S_OPC : S_RESULT;
      default: state_d = S_OPC;
    endcase
  end
  // OPND waits for a pending echo byte to leave so RESULT never finds the output register busy
  always_comb begin
    s_ready_o = !rst & ((state_q inside {S_OPC, S_RSVD, S_LEN_LO, S_LEN_HI, S_DRAIN}) |
                        ((state_q == S_ECHO) & (!out_v_q | m_ready_i)) |
                        ((state_q == S_OPND) & !out_v_q));
    m_valid_o = (state_q == S_RESULT) | out_v_q;
    m_data_o = (state_q == S_RESULT) ? res_byte : out_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      opc_q <= '0;
      len_lo_q <= '0;
      rem_q <= '0;
      shift_q <= '0;
      acc_q <= '0;
      byte_cnt_q <= '0;
      res_cnt_q <= '0;
      first_q <= 1'b0;
      out_q <= '0;
      out_v_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= hdr_err;
      if (s_acc && state_q == S_OPC) opc_q <= s_data_i;
      if (s_acc && state_q == S_LEN_LO) len_lo_q <= s_data_i;
      if (s_acc && state_q == S_LEN_HI) begin
        rem_q <= rem_n;
        byte_cnt_q <= '0;
        first_q <= 1'b1;
      end
      if (s_acc && (state_q inside {S_ECHO, S_OPND, S_DRAIN})) rem_q <= rem_q - 16'd1;
      if (s_acc && state_q == S_OPND) begin
        shift_q <= op;
        byte_cnt_q <= byte_cnt_q + 2'd1;
      end
      if (opnd_done) begin
        first_q <= 1'b0;
        acc_q <= first_q ? op : mul_start ? acc_q : acc_q + op;
      end
      if (state_q == S_MUL_BUSY && mul_done) acc_q <= mul_p;
      if (s_acc && state_q == S_ECHO) begin
        out_q <= s_data_i;
        out_v_q <= 1'b1;
      end else if (m_ready_i) out_v_q <= 1'b0;
      if (state_q == S_RESULT && m_ready_i) res_cnt_q <= res_cnt_q + 2'd1;
    end
  end
endmodule
